// File: rtl/mmu_req_arbiter.sv
// Round-robin arbiter/sequencer sharing the single MMU CPU-side port among NUM_REQ requesters.
// Optional fault logging (fault_count, last_fault_addr) is built when MMU_ARB_FAULT_LOG_EN is defined.
//
// state   | meaning
// S_IDLE  | waiting for any req_valid; grant chosen and accepted combinationally
// S_ISSUE | mmu_en high for one cycle; MMU result sampled at the closing edge
// S_WAIT  | MMU registers its error code; captured at the closing edge
// S_RESP  | one-cycle rsp_valid to the granted requester
module mmu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]   req_we,
  input  logic [NUM_REQ*6-1:0] req_module,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic [31:0]          rsp_err,
  output logic                 mmu_en,
  output logic                 mmu_we,
  output logic [31:0]          mmu_addr,
  output logic [31:0]          mmu_wdata,
  output logic [5:0]           mmu_module,
  input  logic [31:0]          mmu_rdata,
  input  logic                 mmu_access_allowed,
  input  logic [31:0]          mmu_error_code,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx
`ifdef MMU_ARB_FAULT_LOG_EN
  ,
  output logic [15:0]          fault_count,
  output logic [31:0]          last_fault_addr
`endif
);

  localparam int CW = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic             we_q;
  logic             allowed_q;
  logic [31:0]      rdata_q;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic [CW-1:0]    cand_sum;
  logic [IDX_W-1:0] rr_next;
  logic [31:0]      pick_addr;
  logic [31:0]      pick_wdata;
  logic             pick_we;
  logic [5:0]       pick_module;

  // Descending scan so the candidate closest to rr_ptr is the one that sticks.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr} + CW'(k);
      if (cand_sum >= CW'(NUM_REQ)) cand_sum = cand_sum - CW'(NUM_REQ);
      cand = cand_sum[IDX_W-1:0];
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign rr_next     = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign pick_addr   = req_addr[32*pick_idx +: 32];
  assign pick_wdata  = req_wdata[32*pick_idx +: 32];
  assign pick_we     = req_we[pick_idx];
  assign pick_module = req_module[6*pick_idx +: 6];

  always_comb begin
    req_ready = '0;
    if (rst_n && state == S_IDLE && pick_found) req_ready[pick_idx] = 1'b1;
  end

`ifdef MMU_ARB_FAULT_LOG_EN
  logic [31:0] addr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      we_q       <= 1'b0;
      allowed_q  <= 1'b0;
      rdata_q    <= '0;
      busy       <= 1'b0;
      mmu_en     <= 1'b0;
      mmu_we     <= 1'b0;
      mmu_addr   <= '0;
      mmu_wdata  <= '0;
      mmu_module <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= '0;
`ifdef MMU_ARB_FAULT_LOG_EN
      addr_q          <= '0;
      fault_count     <= '0;
      last_fault_addr <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_idx  <= pick_idx;
            rr_ptr     <= rr_next;
            we_q       <= pick_we;
            busy       <= 1'b1;
            mmu_en     <= 1'b1;
            mmu_we     <= pick_we;
            mmu_addr   <= pick_addr;
            mmu_wdata  <= pick_wdata;
            mmu_module <= pick_module;
`ifdef MMU_ARB_FAULT_LOG_EN
            addr_q     <= pick_addr;
`endif
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          allowed_q  <= mmu_access_allowed;
          rdata_q    <= (mmu_access_allowed && !we_q) ? mmu_rdata : 32'h0;
          mmu_en     <= 1'b0;
          mmu_we     <= 1'b0;
          mmu_addr   <= '0;
          mmu_wdata  <= '0;
          mmu_module <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          rsp_valid[grant_idx] <= 1'b1;
          rsp_rdata            <= allowed_q ? rdata_q : 32'h0;
          rsp_err              <= mmu_error_code;
          state                <= S_RESP;
        end
        S_RESP: begin
`ifdef MMU_ARB_FAULT_LOG_EN
          if (rsp_err != 32'h0) begin
            if (fault_count != 16'hFFFF) fault_count <= fault_count + 16'd1;
            last_fault_addr <= addr_q;
          end
`endif
          rsp_valid <= '0;
          rsp_rdata <= '0;
          rsp_err   <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mmu_req_arbiter.md
Name: mmu_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single MMU CPU-side port among NUM_REQ requesters (e.g. core load/store, DMA, partition engine).
- Accepts one request at a time over a valid/ready handshake and drives the MMU for exactly one enable cycle.
- Samples the MMU's combinational result (rdata, access_allowed) and its registered error code one cycle later.
- Returns a one-cycle response to the originating requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the grant index; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept strobe.
- req_addr  input  NUM_REQ*32  packed virtual addresses; requester i occupies bits [32i+31:32i].
- req_wdata  input  NUM_REQ*32  packed write data.
- req_we  input  NUM_REQ  write enable per requester.
- req_module  input  NUM_REQ*6  packed current-module IDs.
- rsp_valid  output  NUM_REQ  one-cycle response strobe per requester.
- rsp_rdata  output  32  read data; shared, qualified by rsp_valid.
- rsp_err  output  32  MMU error code; shared.
- mmu_en  output  1  MMU enable.
- mmu_we  output  1  MMU write enable.
- mmu_addr  output  32  address to MMU.
- mmu_wdata  output  32  write data to MMU.
- mmu_module  output  6  current_module to MMU.
- mmu_rdata  input  32  MMU read data, combinational.
- mmu_access_allowed  input  1  MMU access_allowed, combinational.
- mmu_error_code  input  32  MMU error code, registered one cycle after mmu_en.
- busy  output  1  high in any state except IDLE.
- grant_idx  output  IDX_W  index of the current or most recent grant.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer rr_ptr is 0.
  - Captured registers are 0.
- FSM states and transitions:
  - IDLE: if any req_valid is high, pick the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
    - req_ready[g] is driven combinationally high for that index only, in the same cycle.
    - On that clock edge, latch addr, wdata, we and module of g; set grant_idx=g and rr_ptr=(g+1) mod NUM_REQ; go to ISSUE.
    - If no req_valid is high, stay in IDLE and all req_ready stay 0.
  - ISSUE (1 cycle): mmu_en=1; mmu_we, mmu_addr, mmu_wdata, mmu_module come from the latches.
    - At the edge, capture allowed<=mmu_access_allowed and rdata<=(mmu_access_allowed & ~we) ? mmu_rdata : 0; go to WAIT.
  - WAIT (1 cycle): mmu_en=0. At the edge, capture err<=mmu_error_code; go to RESP.
  - RESP (1 cycle): rsp_valid[grant_idx]=1; rsp_rdata=captured rdata; rsp_err=captured err; go to IDLE.
- Outside their active states, mmu_* outputs and rsp_* outputs are driven 0.
- Latency and throughput:
  - Request accepted at edge T, where req_ready is high in the cycle before T.
  - rsp_valid is high in the cycle after edge T+2 (3 cycles after accept).
  - At most one accept every 4 cycles.
  - A new request may be accepted in the IDLE cycle immediately following RESP.
- Handshake rules:
  - A requester holds req_valid and its fields stable until it sees req_ready.
  - req_valid dropped before ready is legal; no transaction results.
  - After acceptance, req_valid is ignored until the next IDLE.
  - A requester may re-request while its response is pending; the new request is arbitrated only in IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other grants.
- Denied access:
  - rsp_rdata=0 and rsp_err is the MMU code (e.g. 0x1001/0x1002/0x1004).
  - The response is still delivered, and there are no retries.
- Writes: rsp_rdata=0; rsp_err reports the MMU result.
- Reset mid-operation: return immediately to IDLE with rr_ptr=0. The in-flight transaction produces no rsp_valid, and mmu_en drops asynchronously.

Optional Feature:
- Macro MMU_ARB_FAULT_LOG_EN.
- When defined, the block adds two output ports:
  - fault_count (16 bits): saturating count of responses with rsp_err != 0.
  - last_fault_addr (32 bits): latched mmu_addr of the most recent faulting transaction, updated in RESP.
- Both reset to 0; fault_count saturates at 0xFFFF.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single read, allowed: req_valid[1]=1, addr 0x0400_0010, MMU allowed=1, rdata=0xDEADBEEF, error_code=0 -> req_ready[1] pulses once; mmu_en high for exactly 1 cycle; rsp_valid[1] high 3 cycles after accept with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Contention: all 4 req_valid held high for 16 transactions -> grant order 0,1,2,3,0,1,2,3...; each rsp_valid goes to the matching index; accepts are spaced exactly 4 cycles apart.
- Denied write: req 2 write, MMU allowed=0, error_code=0x1002 -> rsp_valid[2] with rsp_rdata=0, rsp_err=0x1002; with MMU_ARB_FAULT_LOG_EN, fault_count=1 and last_fault_addr=the request addr.
- Pointer wrap: grant 3, then only req 0 and req 2 valid -> grant 0 next, then 2.
- Reset mid-operation: assert rst_n low during WAIT -> no rsp_valid, all outputs 0, busy=0; after release, req 3 alone is granted on the first IDLE cycle (rr_ptr=0 search reaches 3).
- Withdrawn request: req_valid[0] is high for one cycle while the FSM is in ISSUE and is low by the next IDLE -> no accept for requester 0 and no spurious response.
